// File: rtl/mul_div_if.sv
// Handshake and result bus of the signed multiply/divide unit.
// The master side issues operations; the slave side (the unit) returns results.
interface mul_div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] z_high;
    logic [WIDTH-1:0] z_low;
    logic             div_by_zero;

    modport master (
        output start, op, a_in, b_in,
        input  busy, done, z_high, z_low, div_by_zero
    );

    modport slave (
        input  start, op, a_in, b_in,
        output busy, done, z_high, z_low, div_by_zero
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative signed multiply (radix-2 Booth) and signed divide (restoring on
// magnitudes). One iteration per clock, WIDTH iterations per operation, then
// a finishing cycle that registers the result and pulses done.
// A divide by zero skips the iterations and completes on the next edge.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic     clock,
    input  logic     clear,
    mul_div_if.slave bus
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH:0]   ZERO_ACC  = {(WIDTH+1){1'b0}};
    localparam logic [CW-1:0]    ZERO_CNT  = {CW{1'b0}};
    localparam logic [CW-1:0]    ONE_CNT   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    LAST_ITER = {CW{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Two's-complement negation.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        negate = ~x + ONE_W;
    endfunction

    // Magnitude of a signed value; the most negative value maps to itself,
    // which reads correctly when interpreted as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
        if (x[WIDTH-1] == 1'b1) begin
            magnitude = negate(x);
        end else begin
            magnitude = x;
        end
    endfunction

    state_t           state_r;
    logic             op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [CW-1:0]    cnt_r;
    // MUL: {acc_r, lo_r, q1_r} is the Booth register (acc one bit wider so the
    // most negative multiplicand cannot overflow it).
    // DIV: acc_r holds the partial remainder, lo_r shifts the dividend out and
    // the quotient in.
    logic [WIDTH:0]   acc_r;
    logic [WIDTH-1:0] lo_r;
    logic             q1_r;
    logic             dz_pend_r;
    logic             busy_r;
    logic             done_r;
    logic             dz_r;
    logic [WIDTH-1:0] z_high_r;
    logic [WIDTH-1:0] z_low_r;

    logic [WIDTH:0]   a_ext_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] mag_b_s;
    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH:0]   step_acc_s;
    logic [WIDTH-1:0] step_lo_s;
    logic             step_q1_s;
    logic [WIDTH-1:0] res_hi_s;
    logic [WIDTH-1:0] res_lo_s;

    // One iteration of Booth multiply or restoring divide, chosen by op_r.
    always_comb begin
        a_ext_s    = {a_r[WIDTH-1], a_r};
        mag_b_s    = magnitude(b_r);
        sum_s      = acc_r;
        rem_sh_s   = {acc_r[WIDTH-1:0], lo_r[WIDTH-1]};
        diff_s     = rem_sh_s - {1'b0, mag_b_s};
        step_acc_s = acc_r;
        step_lo_s  = lo_r;
        step_q1_s  = q1_r;

        case ({lo_r[0], q1_r})
            2'b01:   sum_s = acc_r + a_ext_s;
            2'b10:   sum_s = acc_r - a_ext_s;
            default: sum_s = acc_r;
        endcase

        if (op_r == 1'b0) begin
            // Arithmetic right shift of {sum, multiplier, q-1}.
            {step_acc_s, step_lo_s, step_q1_s} = {sum_s[WIDTH], sum_s, lo_r};
        end else if (diff_s[WIDTH] == 1'b0) begin
            // Divisor fits: keep the difference, quotient bit 1.
            step_acc_s = diff_s;
            step_lo_s  = {lo_r[WIDTH-2:0], 1'b1};
        end else begin
            // Divisor does not fit: restore, quotient bit 0.
            step_acc_s = rem_sh_s;
            step_lo_s  = {lo_r[WIDTH-2:0], 1'b0};
        end
    end

    // Final result: sign correction for divide, plain split for multiply.
    always_comb begin
        res_hi_s = acc_r[WIDTH-1:0];
        res_lo_s = lo_r;
        if (op_r == 1'b1) begin
            res_lo_s = (a_r[WIDTH-1] ^ b_r[WIDTH-1]) ? negate(lo_r) : lo_r;
            res_hi_s = a_r[WIDTH-1] ? negate(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
        end else begin
            res_hi_s = acc_r[WIDTH-1:0];
            res_lo_s = lo_r;
        end
    end

    // Control FSM, operand capture, iteration state and registered outputs.
    always_ff @(posedge clock) begin
        if (clear == 1'b0) begin
            state_r   <= IDLE;
            op_r      <= 1'b0;
            a_r       <= ZERO_W;
            b_r       <= ZERO_W;
            cnt_r     <= ZERO_CNT;
            acc_r     <= ZERO_ACC;
            lo_r      <= ZERO_W;
            q1_r      <= 1'b0;
            dz_pend_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            dz_r      <= 1'b0;
            z_high_r  <= ZERO_W;
            z_low_r   <= ZERO_W;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (dz_pend_r == 1'b1) begin
                        // Divide-by-zero completion: no iterations were run.
                        dz_pend_r <= 1'b0;
                        done_r    <= 1'b1;
                        dz_r      <= 1'b1;
                        z_high_r  <= a_r;
                        z_low_r   <= ONES_W;
                    end else if (bus.start == 1'b1) begin
                        op_r  <= bus.op;
                        a_r   <= bus.a_in;
                        b_r   <= bus.b_in;
                        cnt_r <= ZERO_CNT;
                        dz_r  <= 1'b0;
                        acc_r <= ZERO_ACC;
                        q1_r  <= 1'b0;
                        lo_r  <= (bus.op == 1'b1) ? magnitude(bus.a_in) : bus.b_in;
                        if ((bus.op == 1'b1) && (bus.b_in == ZERO_W)) begin
                            dz_pend_r <= 1'b1;
                        end else begin
                            state_r <= RUN;
                            busy_r  <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    acc_r <= step_acc_s;
                    lo_r  <= step_lo_s;
                    q1_r  <= step_q1_s;
                    cnt_r <= cnt_r + ONE_CNT;
                    if (cnt_r == LAST_ITER) begin
                        state_r <= FIN;
                    end else begin
                        state_r <= RUN;
                    end
                end
                FIN: begin
                    z_high_r <= res_hi_s;
                    z_low_r  <= res_lo_s;
                    done_r   <= 1'b1;
                    busy_r   <= 1'b0;
                    state_r  <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.z_high      = z_high_r;
    assign bus.z_low       = z_low_r;
    assign bus.div_by_zero = dz_r;

endmodule
